// File: rtl/prioq_param.sv
// Parametrised sorted priority queue: highest priority leaves first, equal
// priorities leave in arrival order; independent enqueue/dequeue strobes.
module prioq_param #(
  parameter int unsigned PRIO_W = 2,
  parameter int unsigned ID_W   = 2,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned DW    = PRIO_W + ID_W,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in,
  input  logic          enq,
  input  logic          deq,
  output logic [DW-1:0] out,
  output logic          out_valid,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic          udf
);

  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] base [DEPTH];
  logic [DW-1:0] prev [DEPTH];
  logic [DW-1:0] nxt  [DEPTH];
  logic [CW-1:0] bcnt;
  logic [CW-1:0] pos;
  logic [CW-1:0] cnt_nxt;
  logic          pop;
  logic          push;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    pop  = deq && !empty;
    // A simultaneous pop frees a slot, so a full queue still accepts the item.
    push = enq && (!full || pop);
    bcnt = count - CW'(pop);

    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      base[i] = pop ? mem[i+1] : mem[i];
    end
    base[DEPTH-1] = pop ? '0 : mem[DEPTH-1];

    prev[0] = base[0];
    for (int unsigned i = 1; i < DEPTH; i++) begin
      prev[i] = base[i-1];
    end

    // Array is sorted, so the slot after the last entry with prio >= new
    // equals the number of valid entries with prio >= new.
    pos = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < bcnt) && (base[i][DW-1:ID_W] >= in[DW-1:ID_W])) begin
        pos = pos + CW'(1);
      end
    end

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!push || (CW'(i) < pos)) begin
        nxt[i] = base[i];
      end else if (CW'(i) == pos) begin
        nxt[i] = in;
      end else begin
        nxt[i] = prev[i];
      end
    end

    cnt_nxt = bcnt + CW'(push);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      count     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= nxt[i];
      end
      count     <= cnt_nxt;
      out_valid <= pop;
      if (pop) begin
        out <= mem[0];
      end
      ovf <= enq && !deq && full;
      udf <= deq && empty;
    end
  end

endmodule
